// File: rtl/avl_pio_gpio.sv
// Avalon-MM GPIO slave: per-pin direction, atomic set/clear, synchronised inputs.
// Optional edge capture + maskable irq built only when AVL_PIO_GPIO_EDGE_IRQ_EN is defined.
module avl_pio_gpio #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] OUT_RESET = 32'h0,
    parameter logic [31:0] DIR_RESET = 32'h0,
    parameter int          EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_IRQMASK = 3'd2;
    localparam logic [2:0] A_EDGECAP = 3'd3;
    localparam logic [2:0] A_OUTSET  = 3'd4;
    localparam logic [2:0] A_OUTCLR  = 3'd5;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync_in;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= OUT_RESET[WIDTH-1:0];
        end else if (w_wr) begin
            case (address)
                A_DATA:   r_data_out <= w_wdata;
                A_OUTSET: r_data_out <= r_data_out | w_wdata;
                A_OUTCLR: r_data_out <= r_data_out & ~w_wdata;
                default:  r_data_out <= r_data_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir <= DIR_RESET[WIDTH-1:0];
        end else if (w_wr && (address == A_DIR)) begin
            r_dir <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta    <= '0;
            r_sync_in <= '0;
        end else begin
            r_meta    <= in_port;
            r_sync_in <= r_meta;
        end
    end

    assign out_port = r_data_out;
    assign out_en   = r_dir;

`ifdef AVL_PIO_GPIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_sync_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [1:0]       r_settle;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;

    always_comb begin
        w_edge_raw = '0;
        case (EDGE_TYPE)
            0:       w_edge_raw = r_sync_in & ~r_sync_prev;
            1:       w_edge_raw = ~r_sync_in & r_sync_prev;
            default: w_edge_raw = r_sync_in ^ r_sync_prev;
        endcase
    end

    // Suppress edges until the synchroniser holds real pin state, not reset zeros.
    assign w_edge = (r_settle == 2'd3) ? w_edge_raw : '0;
    assign w_clr  = (w_wr && (address == A_EDGECAP)) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_prev <= '0;
            r_settle    <= 2'd0;
        end else begin
            r_sync_prev <= r_sync_in;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
        end else if (w_wr && (address == A_IRQMASK)) begin
            r_irqmask <= w_wdata;
        end
    end

    // A new edge overrides a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd = '0;
        case (address)
            A_DATA: w_rd = (r_dir & r_data_out) | (~r_dir & r_sync_in);
            A_DIR:  w_rd = r_dir;
`ifdef AVL_PIO_GPIO_EDGE_IRQ_EN
            A_IRQMASK: w_rd = r_irqmask;
            A_EDGECAP: w_rd = r_edgecap;
`endif
            default: w_rd = '0;
        endcase
    end

    always_comb begin
        readdata = '0;
        readdata[WIDTH-1:0] = w_rd;
    end

endmodule

// File: tb/tb_avl_pio_gpio.sv
// Scoreboard bench for avl_pio_gpio: stimulus queues expectations, a negedge monitor compares.
module tb_avl_pio_gpio;

`ifdef AVL_PIO_GPIO_EDGE_IRQ_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   localparam int S_RD  = 0;
   localparam int S_OUT = 1;
   localparam int S_OE  = 2;
   localparam int S_IRQ = 3;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic [7:0]  out_en;
   logic        irq;
   logic        done;

   avl_pio_gpio #(
      .WIDTH(8), .OUT_RESET(32'hA5), .DIR_RESET(32'hFF), .EDGE_TYPE(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .out_port(out_port), .out_en(out_en), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } item_t;

   item_t       sb_q[$];
   item_t       m_it;
   logic [31:0] m_act;
   int          n_chk  = 0;
   int          n_pass = 0;

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         m_it = sb_q.pop_front();
         case (m_it.sel)
            S_RD:    m_act = readdata;
            S_OUT:   m_act = {24'h0, out_port};
            S_OE:    m_act = {24'h0, out_en};
            default: m_act = {31'h0, irq};
         endcase
         n_chk++;
         if (m_act === m_it.exp) n_pass++;
         else $display("FAIL %s: actual %h required %h", m_it.name, m_act, m_it.exp);
      end
   end

   initial begin
      done = 1'b0;
      #200000;
      if (!done) begin
         $display("FAIL timeout: test did not complete");
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input int sel, input logic [31:0] exp, input string name);
      item_t it;
      it.sel  = sel;
      it.exp  = exp;
      it.name = name;
      sb_q.push_back(it);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      chk(S_RD, exp, name);
      tick();
      chipselect = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = 8'hFF;
      tick();

      n_chk++;
      if (out_port === 8'hA5 && out_en === 8'hFF && irq === 1'b0) n_pass++;
      else $display("FAIL reset_direct: out_port %h out_en %h irq %b", out_port, out_en, irq);

      chk(S_OUT, 32'hA5, "reset_out_port");
      chk(S_OE,  32'hFF, "reset_out_en");
      chk(S_IRQ, 32'h0,  "reset_irq");
      rd(3'd0, 32'h0000_00A5, "reset_rd_data");

      reset_n = 1'b1;
      ticks(5);
      rd(3'd3, 32'h0, "settle_no_capture");
      chk(S_IRQ, 32'h0, "settle_no_irq");
      tick();

      chk(S_OUT, 32'hA5, "data_before_write");
      wr(3'd0, 32'hFFFF_FF0F);
      chk(S_OUT, 32'h0F, "data_write");
      wr(3'd4, 32'h30);
      chk(S_OUT, 32'h3F, "outset");
      wr(3'd5, 32'h01);
      chk(S_OUT, 32'h3E, "outclr");
      wr(3'd6, 32'hFF);
      wr(3'd7, 32'h00);
      chk(S_OUT, 32'h3E, "addr67_ignored");
      rd(3'd4, 32'h0, "rd_outset_zero");
      rd(3'd5, 32'h0, "rd_outclr_zero");
      rd(3'd6, 32'h0, "rd_addr6_zero");
      rd(3'd0, 32'h3E, "rd_data_dir_out");

      wr(3'd1, 32'h00);
      chk(S_OE, 32'h00, "dir_write");
      in_port = 8'h00;
      ticks(4);
      wr(3'd3, 32'hFF);
      in_port = 8'h81;
      rd(3'd0, 32'h00, "sync_edge0");
      rd(3'd0, 32'h00, "sync_edge1");
      rd(3'd0, 32'h81, "sync_edge2");
      rd(3'd3, EN ? 32'h81 : 32'h0, "edgecap_81");
      wr(3'd3, 32'hFF);
      rd(3'd3, 32'h0, "edgecap_cleared");
      wr(3'd1, 32'hF0);
      rd(3'd0, 32'h31, "rd_data_mixed_dir");
      rd(3'd1, 32'hF0, "rd_dir");
      wr(3'd1, 32'h00);

      wr(3'd2, 32'h01);
      rd(3'd2, EN ? 32'h01 : 32'h0, "rd_irqmask");
      in_port = 8'h80;
      ticks(4);
      rd(3'd3, 32'h0, "fall_no_capture");
      in_port = 8'h81;
      chk(S_IRQ, 32'h0, "rise_irq_e0");
      ticks(2);
      chk(S_IRQ, 32'h0, "rise_irq_e2");
      tick();
      chk(S_IRQ, EN ? 32'h1 : 32'h0, "rise_irq_e3");
      rd(3'd3, EN ? 32'h01 : 32'h0, "rise_edgecap");
      chk(S_IRQ, EN ? 32'h1 : 32'h0, "irq_before_clear");
      wr(3'd3, 32'h01);
      chk(S_IRQ, 32'h0, "irq_after_clear");
      rd(3'd3, 32'h0, "edgecap_after_clear");
      in_port = 8'h80;
      ticks(4);
      rd(3'd3, 32'h0, "fall2_no_capture");
      chk(S_IRQ, 32'h0, "fall2_no_irq");

      wr(3'd2, 32'h04);
      in_port = 8'h81;
      ticks(4);
      chk(S_IRQ, 32'h0, "unmasked_no_irq");
      rd(3'd3, EN ? 32'h01 : 32'h0, "bit0_captured");
      in_port = 8'h85;
      ticks(2);
      wr(3'd3, 32'h05);
      chk(S_IRQ, EN ? 32'h1 : 32'h0, "set_wins_irq");
      rd(3'd3, EN ? 32'h04 : 32'h0, "set_wins_edgecap");

      reset_n = 1'b0;
      chk(S_OUT, 32'hA5, "midreset_out_port");
      chk(S_OE,  32'hFF, "midreset_out_en");
      chk(S_IRQ, 32'h0,  "midreset_irq");
      rd(3'd0, 32'hA5, "midreset_rd_data");
      reset_n = 1'b1;
      ticks(5);
      rd(3'd3, 32'h0, "resettle_edgecap");
      rd(3'd2, 32'h0, "resettle_irqmask");
      chk(S_IRQ, 32'h0, "resettle_irq");
      ticks(2);

      done = 1'b1;
      if (n_pass != n_chk || n_chk == 0) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
